// File: rtl/time_multiplexing_stopwatch.sv
// time_multiplexing_stopwatch: 4-digit BCD up/down stopwatch (XX.XX s) driving a
// time-multiplexed common-anode 7-segment display.
module time_multiplexing_stopwatch #(
    parameter int TICK_DIV    = 1_000_000,
    parameter int REFRESH_DIV = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startstop,
    input  logic [7:0] sw,
    input  logic [1:0] mode,
    output logic       dp,
    output logic [3:0] an,
    output logic [6:0] sseg
);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int RW = $clog2(REFRESH_DIV + 1);

    logic [2:0]    sync;
    logic [15:0]   count, count_n, preset, cur, terminal;
    logic          run, run_n, fresh, fresh_n, dir, down, start_edge, step, rdone;
    logic [TW-1:0] tick, tick_n;
    logic [RW-1:0] refresh, refresh_n;
    logic [1:0]    sel, sel_n;

    function automatic logic [3:0] sat(input logic [3:0] x);
        return x > 4'd9 ? 4'd9 : x;
    endfunction

    function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic dn);
        logic [15:0] r;
        logic        c;
        logic [3:0]  d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                r[4*i +: 4] = dn ? (d == 4'd0 ? 4'd9 : d - 4'd1) : (d == 4'd9 ? 4'd0 : d + 4'd1);
                c = dn ? d == 4'd0 : d == 4'd9;
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Until the first start, preset and direction track mode/sw live.
    always_comb begin
        start_edge = sync[1] & ~sync[2];
        preset     = mode == 2'd0 ? 16'h0000 : mode == 2'd2 ? 16'h9999 : {sat(sw[7:4]), sat(sw[3:0]), 8'h00};
        cur        = fresh ? preset : count;
        down       = fresh ? mode[1] : dir;
        terminal   = down ? 16'h0000 : 16'h9999;
        step       = run && tick == TW'(TICK_DIV - 1);
        count_n    = step ? bcd_step(cur, down) : cur;
        tick_n     = run && !step ? tick + 1'b1 : '0;
        run_n      = start_edge ? !run && cur != terminal : (step && count_n == terminal) ? 1'b0 : run;
        fresh_n    = fresh && !start_edge;
        rdone      = refresh == RW'(REFRESH_DIV - 1);
        refresh_n  = rdone ? '0 : refresh + 1'b1;
        sel_n      = sel + {1'b0, rdone};
    end

    // Display outputs are registered from next-state so an and sseg change together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync    <= '0;
            count   <= '0;
            run     <= 1'b0;
            fresh   <= 1'b1;
            dir     <= 1'b0;
            tick    <= '0;
            refresh <= '0;
            sel     <= '0;
            an      <= 4'b1110;
            sseg    <= 7'b1000000;
            dp      <= 1'b1;
        end else begin
            sync    <= {sync[1:0], startstop};
            count   <= count_n;
            run     <= run_n;
            fresh   <= fresh_n;
            dir     <= down;
            tick    <= tick_n;
            refresh <= refresh_n;
            sel     <= sel_n;
            an      <= ~(4'b0001 << sel_n);
            sseg    <= seg(count_n[{sel_n, 2'b00} +: 4]);
            dp      <= sel_n != 2'd2;
        end
    end
endmodule

// File: tb/tb_time_multiplexing_stopwatch.sv
// tb_time_multiplexing_stopwatch: randomized and directed checks against an integer
// centisecond model of the stopwatch and display scan.
module tb_time_multiplexing_stopwatch;
    localparam int TICK = 4;
    localparam int REF  = 2;

    logic       clk = 0, reset = 1, startstop = 0;
    logic [7:0] sw = 0;
    logic [1:0] mode = 0;
    logic       dp;
    logic [3:0] an;
    logic [6:0] sseg;

    int checks = 0, failures = 0;

    time_multiplexing_stopwatch #(.TICK_DIV(TICK), .REFRESH_DIV(REF)) dut (
        .clk(clk), .reset(reset), .startstop(startstop), .sw(sw), .mode(mode),
        .dp(dp), .an(an), .sseg(sseg)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    int p10 [4] = '{1, 10, 100, 1000};

    // Model state: count in centiseconds, plain integers throughout.
    int         m_cs = 0, m_tp = 0, m_rp = 0, m_sel = 0;
    bit         m_run = 0, m_fresh = 1, m_dn = 0;
    logic [2:0] q = 0;

    function automatic int sat(input logic [3:0] x);
        return x > 9 ? 9 : int'(x);
    endfunction

    function automatic int dec(input logic [6:0] s);
        for (int i = 0; i < 10; i++) if (seg_tab[i] == s) return i;
        return 15;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin : mdl
        int  pre, cur, nxt, term;
        bit  edg, stp, dn;
        if (reset) begin
            q <= 0; m_cs <= 0; m_run <= 0; m_fresh <= 1; m_dn <= 0;
            m_tp <= 0; m_rp <= 0; m_sel <= 0;
        end else begin
            edg  = q[1] && !q[2];
            pre  = mode == 0 ? 0 : mode == 2 ? 9999 : sat(sw[7:4]) * 1000 + sat(sw[3:0]) * 100;
            dn   = m_fresh ? mode[1] : m_dn;
            cur  = m_fresh ? pre : m_cs;
            term = dn ? 0 : 9999;
            stp  = m_run && m_tp == TICK - 1;
            nxt  = stp ? (dn ? cur - 1 : cur + 1) : cur;
            q     <= {q[1:0], startstop};
            m_dn  <= dn;
            m_cs  <= nxt;
            m_tp  <= (m_run && !stp) ? m_tp + 1 : 0;
            if (edg) begin
                m_fresh <= 0;
                m_run   <= !m_run && cur != term;
            end else if (stp && nxt == term) m_run <= 0;
            m_rp  <= m_rp == REF - 1 ? 0 : m_rp + 1;
            m_sel <= m_rp == REF - 1 ? (m_sel + 1) % 4 : m_sel;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("an", an, 15 & ~(1 << m_sel));
            check("dp", dp, m_sel != 2);
            check("sseg", sseg, seg_tab[(m_cs / p10[m_sel]) % 10]);
        end
    end

    task automatic read_disp(output int v);
        int dg [4] = '{15, 15, 15, 15};
        logic [3:0] pat;
        repeat (8) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                pat = 4'b0001 << k;
                if (an == ~pat) dg[k] = dec(sseg);
            end
        end
        v = (dg[0] > 9 || dg[1] > 9 || dg[2] > 9 || dg[3] > 9) ? -1
            : dg[3] * 1000 + dg[2] * 100 + dg[1] * 10 + dg[0];
    endtask

    task automatic do_reset(input logic [1:0] m, input logic [7:0] s);
        @(negedge clk);
        mode = m; sw = s; reset = 1;
        @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic press(input int hold);
        @(negedge clk);
        startstop = 1;
        repeat (hold) @(negedge clk);
        startstop = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_stop(input int budget);
        int n = 0;
        while (m_run && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("stop_in_time", m_run, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int v, v1, v2;
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'b1110);
        check("rst_dp", dp, 1);
        check("rst_sseg", sseg, 7'b1000000);
        reset = 0;

        do_reset(0, 8'h00);
        read_disp(v); check("m0_preset", v, 0);
        press(2);
        repeat (20) @(negedge clk);
        press(2);
        read_disp(v1); check("m0_model", v1, m_cs);
        check("m0_counted", v1 > 0, 1);
        repeat (50) @(negedge clk);
        read_disp(v2); check("frozen", v2, v1);
        press(2);
        repeat (12) @(negedge clk);
        press(2);
        read_disp(v); check("resumed", v > v1, 1);

        do_reset(1, 8'h88);
        read_disp(v); check("m1_preset88", v, 8800);
        do_reset(1, 8'h99);
        read_disp(v); check("m1_preset99", v, 9900);
        press(2);
        wait_stop(600);
        read_disp(v); check("m1_terminal", v, 9999);
        press(2);
        repeat (20) @(negedge clk);
        read_disp(v); check("m1_term_hold", v, 9999);

        do_reset(2, 8'h00);
        read_disp(v); check("m2_preset", v, 9999);
        press(2);
        repeat (30) @(negedge clk);
        press(2);
        read_disp(v); check("m2_model", v, m_cs);
        check("m2_counted", v < 9999, 1);

        do_reset(3, 8'h01);
        read_disp(v); check("m3_preset", v, 100);
        press(1);
        mode = 0; sw = 8'h55;
        wait_stop(600);
        read_disp(v); check("m3_terminal", v, 0);
        press(3);
        repeat (20) @(negedge clk);
        read_disp(v); check("m3_term_hold", v, 0);

        do_reset(3, 8'hFA);
        read_disp(v); check("m3_sat", v, 9900);
        press(2);
        repeat (9) @(negedge clk);
        reset = 1;
        #1;
        check("async_an", an, 4'b1110);
        check("async_dp", dp, 1);
        check("async_sseg", sseg, 7'b1000000);
        @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);
        read_disp(v); check("reload", v, 9900);

        for (int r = 0; r < 25; r++) begin
            do_reset(2'($urandom_range(3, 0)), 8'($urandom));
            repeat ($urandom_range(4, 1)) begin
                repeat ($urandom_range(40, 0)) @(negedge clk);
                if ($urandom_range(3, 0) == 0) begin
                    mode = 2'($urandom_range(3, 0));
                    sw   = 8'($urandom);
                end
                @(negedge clk);
                startstop = 1;
                repeat ($urandom_range(4, 1)) @(negedge clk);
                startstop = 0;
            end
            repeat (20) @(negedge clk);
            if (!m_run) begin
                read_disp(v);
                check("rand_val", v, m_cs);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
